// File: rtl/uart_tx_sched.sv
// Transmit scheduler: byte FIFO feeding a UART TX core one strobe at a time.
// Optional empty interrupt enabled by defining UART_TX_SCHED_IRQ_EN.
module uart_tx_sched #(
  parameter int DEPTH = 8,
  parameter int TMO   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     tx_status,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy
`ifdef UART_TX_SCHED_IRQ_EN
  ,
  output logic                     irq_empty,
  input  logic                     irq_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q, overflow_q, overflow_d;
  logic            busy_q, tx_send_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      mem_q [DEPTH];
  logic            push_ok, load;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && tx_status && !flush) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A transmitter that never reports busy is treated as having taken the byte.
        if (!tx_status) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(TMO - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_status) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A push while full is dropped even if the FSM pops in the same cycle.
  always_comb begin
    push_ok    = wr_en && !flush && !full_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en && full_q);
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (load)    rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      busy_q     <= (state_d != IDLE);
      tx_send_q  <= (state_q == SEND);
      if (load) tx_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

`ifdef UART_TX_SCHED_IRQ_EN
  logic irq_q, irq_d, idle_entry_q;

  // Set on the cycle after returning to IDLE with nothing left; set beats clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr || wr_en)          irq_d = 1'b0;
    if (idle_entry_q && empty_q)   irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q        <= 1'b0;
      idle_entry_q <= 1'b0;
    end else begin
      irq_q        <= irq_d;
      idle_entry_q <= (state_d == IDLE) && (state_q != IDLE);
    end
  end

  assign irq_empty = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected bytes queued at push time,
// a monitor checks every tx_send strobe against the queue head.
module tb_uart_tx_sched;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_status = 1'b1;
  logic [7:0] tx_data;
  logic       tx_send, full, empty, overflow, busy;
  logic [3:0] count;
`ifdef UART_TX_SCHED_IRQ_EN
  logic       irq_empty;
  logic       irq_clr = 1'b0;
`endif

  int nvec = 0, nmis = 0, cyc = 0, strobes = 0, mode = 1, bcnt = 0, push_cyc = 0;
  logic [7:0] exp_q[$];
  int         st_cyc[$];

  uart_tx_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .tx_status(tx_status), .tx_data(tx_data), .tx_send(tx_send), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .busy(busy)
`ifdef UART_TX_SCHED_IRQ_EN
    , .irq_empty(irq_empty), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: 0 = stuck busy, 1 = busy 10 cycles after each strobe,
  // 2 = always idle, 3 = driven directly by the stimulus.
  initial forever begin
    @(negedge clk);
    case (mode)
      0: tx_status = 1'b0;
      1: begin
        if (tx_send === 1'b1) bcnt = 10;
        if (bcnt > 0) begin tx_status = 1'b0; bcnt--; end
        else tx_status = 1'b1;
      end
      2: tx_status = 1'b1;
      default: ;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (tx_send === 1'b1) begin
      strobes++;
      st_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL tx_byte: strobe with data %02h, expected no strobe", tx_data);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    wr_en = 1'b1;
    wr_data = b;
    if (accepted) exp_q.push_back(b);
    tick(1);
    wr_en = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int k = 0;
    while (strobes < target && k < budget) begin tick(1); k++; end
    check(name, strobes, target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && k < budget) begin tick(1); k++; end
    check(name, {30'h0, busy, empty}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    logic [2:0] rp, wp;
    #12;
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
`ifdef UART_TX_SCHED_IRQ_EN
    check("rst_irq", irq_empty, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);

    // Single byte with a realistic transmitter
    mode = 1;
    push(8'h41, 1);
    check("t1_count_after_push", count, 1);
    check("t1_empty_after_push", empty, 0);
    wait_strobes(1, 10, "t1_strobes");
    if (st_cyc.size() > 0) check("t1_latency", st_cyc[0] - push_cyc, 2);
    tick(3);
    check("t1_busy_while_tx", busy, 1);
    wait_idle(40, "t1_idle");
    check("t1_count_end", count, 0);

    // Overflow: 9 pushes into 8 entries while transmitter is stuck busy
    mode = 0;
    tick(2);
    base = strobes;
    for (int i = 0; i < 8; i++) push(8'(i), 1);
    check("t2_full", full, 1);
    check("t2_count8", count, 8);
    check("t2_no_ovf_yet", overflow, 0);
    push(8'h08, 0);
    check("t2_overflow", overflow, 1);
    check("t2_count_still8", count, 8);
    check("t2_full_still", full, 1);
    mode = 1;
    wait_strobes(base + 8, 250, "t2_strobes");
    wait_idle(40, "t2_idle");
    check("t2_sb_drained", exp_q.size(), 0);

    // Simultaneous push and pop at count=3
    mode = 3;
    tx_status = 1'b0;
    base = strobes;
    push(8'hA0, 1);
    push(8'hA1, 1);
    push(8'hA2, 1);
    check("t3_count3", count, 3);
    rp = dut.rd_ptr_q;
    wp = dut.wr_ptr_q;
    wr_en = 1'b1;
    wr_data = 8'hA3;
    exp_q.push_back(8'hA3);
    tx_status = 1'b1;
    tick(1);
    wr_en = 1'b0;
    tx_status = 1'b0;
    check("t3_count_same", count, 3);
    check("t3_rd_ptr", dut.rd_ptr_q, 3'(rp + 3'd1));
    check("t3_wr_ptr", dut.wr_ptr_q, 3'(wp + 3'd1));
    mode = 1;
    wait_strobes(base + 4, 100, "t3_strobes");
    wait_idle(40, "t3_idle");

    // Wrap-around: 20 bytes through the 8-entry FIFO, pushing only when not full
    base = strobes;
    for (int i = 0; i < 20; i++) begin
      k = 0;
      while (full === 1'b1 && k < 50) begin tick(1); k++; end
      push(8'h60 + 8'(i), 1);
    end
    wait_strobes(base + 20, 600, "t3_wrap_strobes");
    wait_idle(40, "t3_wrap_idle");
    check("t3_wrap_sb", exp_q.size(), 0);

    // Timeout path: transmitter never reports busy
    mode = 2;
    tick(2);
    base = strobes;
    push(8'hB0, 1);
    push(8'hB1, 1);
    push(8'hB2, 1);
    wait_strobes(base + 3, 100, "t4_strobes");
    if (st_cyc.size() >= base + 3) begin
      check("t4_spacing1", st_cyc[base + 1] - st_cyc[base], TMO + 2);
      check("t4_spacing2", st_cyc[base + 2] - st_cyc[base + 1], TMO + 2);
    end
    wait_idle(40, "t4_idle");
    check("t4_ovf_sticky", overflow, 1);

    // Flush during WAIT_DONE with 5 bytes queued
    mode = 3;
    tx_status = 1'b0;
    tick(1);
    base = strobes;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1);
    check("t5_count6", count, 6);
    tx_status = 1'b1;
    tick(1);
    tx_status = 1'b0;
    tick(3);
    check("t5_strobe_c0", strobes, base + 1);
    check("t5_count5", count, 5);
    check("t5_busy_before", busy, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    check("t5_count_flushed", count, 0);
    check("t5_ovf_cleared", overflow, 0);
    check("t5_empty", empty, 1);
    check("t5_busy_inflight", busy, 1);
    base = strobes;
    mode = 1;
    tick(30);
    check("t5_no_more_strobes", strobes, base);
    check("t5_idle", busy, 0);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    flush = 1'b1;
    tick(1);
    wr_en = 1'b0;
    flush = 1'b0;
    check("t5_push_flush_count", count, 0);
    tick(5);
    check("t5_push_flush_nosend", strobes, base);

`ifdef UART_TX_SCHED_IRQ_EN
    base = strobes;
    push(8'hE0, 1);
    push(8'hE1, 1);
    wait_strobes(base + 2, 60, "irq_strobes");
    k = 0;
    while (busy === 1'b1 && k < 40) begin tick(1); k++; end
    check("irq_low_at_idle_entry", irq_empty, 0);
    tick(1);
    check("irq_set", irq_empty, 1);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    check("irq_cleared", irq_empty, 0);
`endif

    // Reset while tx_send is high, i.e. first cycle of WAIT_BUSY
    mode = 2;
    tick(1);
    base = strobes;
    push(8'hD0, 1);
    push(8'hD1, 1);
    k = 0;
    while (tx_send !== 1'b1 && k < 10) begin tick(1); k++; end
    check("t6_send_seen", tx_send, 1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t6_send_async_low", tx_send, 0);
    check("t6_count", count, 0);
    check("t6_busy", busy, 0);
    check("t6_tx_data", tx_data, 8'h00);
`ifdef UART_TX_SCHED_IRQ_EN
    check("t6_irq", irq_empty, 0);
`endif
    tick(1);
    reset = 1'b0;
    tick(5);
    check("t6_no_strobe_after_reset", strobes, base);
    check("t6_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler for the memory-mapped UART. It buffers CPU-written bytes in a small FIFO and feeds them one at a time into the UART transmitter. It owns the transmitter's data byte and one-cycle send strobe, and paces itself on the transmitter's idle status. It sits between the peripheral register decode, which presents the write strobe and data, and the UART TX core, so the CPU can queue several bytes without polling status per byte.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64
- TMO, 16: cycles to wait for tx_status to drop after a send strobe before treating the byte as sent

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  push wr_data this cycle
- wr_data  in  8  byte to queue
- flush  in  1  synchronous FIFO clear
- tx_status  in  1  1 = UART transmitter idle/ready
- tx_data  out  8  byte presented to transmitter; reset 8'h00
- tx_send  out  1  one-cycle send strobe; reset 0
- full  out  1  FIFO full; reset 0
- empty  out  1  FIFO empty; reset 1
- count  out  $clog2(DEPTH)+1  stored entries; reset 0
- overflow  out  1  sticky, set on push while full; cleared by flush or reset; reset 0
- busy  out  1  FSM not in IDLE; reset 0
- irq_empty  out  1  present only with UART_TX_SCHED_IRQ_EN; reset 0
- irq_clr  in  1  present only with UART_TX_SCHED_IRQ_EN; clears irq_empty

## Operation
- FIFO: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- count is the registered occupancy. full = (count==DEPTH). empty = (count==0).
- Push while full: data dropped, pointers and count unchanged, overflow set. This holds even if a pop occurs the same cycle.
- Simultaneous push and pop, not full: count unchanged and both pointers advance.
- flush: rd_ptr, wr_ptr, count and overflow cleared. A push in the same cycle is discarded. Flush does not abort a byte already in SEND/WAIT_BUSY/WAIT_DONE.
- FSM states:
  - IDLE: if !empty && tx_status, load tx_data from FIFO head, pop, go to SEND.
  - SEND: tx_send=1 for this cycle only; clear timer; go to WAIT_BUSY.
  - WAIT_BUSY: if !tx_status, go to WAIT_DONE. Else if timer==TMO-1, go to IDLE (timeout: byte assumed sent). Else timer+1.
  - WAIT_DONE: if tx_status, go to IDLE.
- tx_data holds its value until the next load and is never changed outside IDLE→SEND.
- Pop in IDLE is suppressed when flush is high that cycle.
- Reset mid-operation: FSM to IDLE, FIFO emptied, tx_send deasserted immediately (asynchronously). Any byte in flight is abandoned.

## Timing
- All outputs are registered.
- Push at edge N: empty=0 and count updated after N.
- First tx_send is high between edges N+2 and N+3, given the FSM is in IDLE and tx_status=1 at edge N+1.
- tx_data is valid when tx_send rises and stays stable for at least the whole WAIT_BUSY/WAIT_DONE period.
- Minimum byte-to-byte spacing: 4 cycles (SEND, WAIT_BUSY, WAIT_DONE with immediate tx_status return, IDLE).
- Timeout path worst case: TMO+2 cycles per byte.
- tx_status is sampled synchronously and is assumed already synchronous to clk.

## Configuration
- UART_TX_SCHED_IRQ_EN defined:
  - irq_empty and irq_clr ports exist.
  - irq_empty sets on the cycle after the FSM returns to IDLE with the FIFO empty (last byte finished).
  - It stays high until irq_clr, reset, or a new push. Set has priority over clear in the same cycle.
- Not defined: both ports and the logic are absent; behaviour is otherwise identical.

## Test plan
- Reset, then push 8'h41 with tx_status=1 held and a model that drops tx_status for 10 cycles after each strobe → one tx_send pulse with tx_data=8'h41 exactly two cycles after the push edge; busy is 1 until tx_status returns; count returns to 0.
- DEPTH=8: push 9 bytes 8'h00..8'h08 back-to-back with tx_status=0 → full=1 after 8 pushes, overflow=1, count=8. Release tx_status → exactly 8 strobes carrying 8'h00..8'h07 in order.
- Push and pop in the same cycle at count=3 → count stays 3 and rd_ptr and wr_ptr each advance by 1. Wrap-around: 20 bytes through DEPTH=8 arrive in order.
- tx_status held at 1 (transmitter never signals busy) → each byte strobes, times out after TMO=16 cycles, and the next byte strobes at TMO+2 spacing.
- Flush asserted while in WAIT_DONE with 5 queued → count=0 and overflow=0 next cycle; the in-flight byte completes and no further tx_send occurs.
- With UART_TX_SCHED_IRQ_EN: send 2 bytes → irq_empty=1 one cycle after the final IDLE entry. Assert irq_clr → 0. Assert reset mid-WAIT_BUSY → tx_send=0, count=0, irq_empty=0.
